// File: rtl/lsq_pkg.sv
// Shared definitions for the MEM-stage load/store queue: load-type bit
// positions, result-bus layout helpers and the per-entry control record.
package lsq_pkg;

  localparam int LD_TYPE_W = 5;
  localparam int LD_W      = 4;
  localparam int LD_B      = 3;
  localparam int LD_H      = 2;
  localparam int LD_BU     = 1;
  localparam int LD_HU     = 0;

  // mem_rf_bus = {res_from_mem, csr_re, rf_we, rf_waddr, rf_wdata}
  function automatic int rf_bus_w(input int xlen, input int rfa_w);
    return xlen + rfa_w + 3;
  endfunction

  function automatic int rf_waddr_lsb(input int xlen);
    return xlen;
  endfunction

  function automatic int rf_we_bit(input int xlen, input int rfa_w);
    return xlen + rfa_w;
  endfunction

  // Width-independent part of a queue entry; wide fields live in side arrays.
  typedef struct packed {
    logic                 v;
    logic [LD_TYPE_W-1:0] ld_type;
    logic                 res_from_mem;
    logic                 csr_re;
    logic                 rf_we;
    logic                 exc;
    logic                 req;
    logic                 got;
  } lsq_ctrl_t;

endpackage

// File: rtl/mem_stage_lsq_if.sv
// EX -> MEM -> WB handshake and SRAM response bundle for the MEM stage.
interface mem_stage_lsq_if
  import lsq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int RFA_W = 5
) ();

  localparam int DW    = $clog2(DEPTH) + 2;
  localparam int BUS_W = rf_bus_w(XLEN, RFA_W);

  logic                   ex_valid;
  logic                   ex_allowin;
  logic [XLEN-1:0]        ex_pc;
  logic                   ex_req;
  logic [LD_TYPE_W-1:0]   ex_ld_type;
  logic                   ex_res_from_mem;
  logic                   ex_csr_re;
  logic                   ex_rf_we;
  logic [RFA_W-1:0]       ex_rf_waddr;
  logic [XLEN-1:0]        ex_alu_result;
  logic                   ex_exc;
  logic                   flush;
  logic                   data_ok;
  logic [XLEN-1:0]        rdata;
  logic                   wb_allowin;
  logic                   mem_wb_valid;
  logic [XLEN-1:0]        mem_pc;
  logic [BUS_W-1:0]       mem_rf_bus;
  logic                   mem_exc;
  logic [XLEN-1:0]        mem_alu_result;
  logic [DEPTH-1:0]       blk_we;
  logic [DEPTH*RFA_W-1:0] blk_waddr;
  logic [DW-1:0]          discard_cnt;

  modport master (
    output ex_valid, ex_pc, ex_req, ex_ld_type, ex_res_from_mem, ex_csr_re,
           ex_rf_we, ex_rf_waddr, ex_alu_result, ex_exc, flush, data_ok,
           rdata, wb_allowin,
    input  ex_allowin, mem_wb_valid, mem_pc, mem_rf_bus, mem_exc,
           mem_alu_result, blk_we, blk_waddr, discard_cnt
  );

  modport slave (
    input  ex_valid, ex_pc, ex_req, ex_ld_type, ex_res_from_mem, ex_csr_re,
           ex_rf_we, ex_rf_waddr, ex_alu_result, ex_exc, flush, data_ok,
           rdata, wb_allowin,
    output ex_allowin, mem_wb_valid, mem_pc, mem_rf_bus, mem_exc,
           mem_alu_result, blk_we, blk_waddr, discard_cnt
  );

endinterface

// File: rtl/mem_stage_lsq_ld_align.sv
// Load-data aligner: shifts the addressed byte/half to bit 0 and extends it.
module mem_ld_align
  import lsq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]      data,
  input  logic [1:0]           addr,
  input  logic [LD_TYPE_W-1:0] ld_type,
  output logic [XLEN-1:0]      result
);

  logic [XLEN-1:0] shifted;

  assign shifted = data >> {addr, 3'b000};

  // Pick the extension by load type; word loads pass the raw data through.
  always_comb begin
    result = data;
    if (ld_type[LD_B])       result = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
    else if (ld_type[LD_H])  result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
    else if (ld_type[LD_BU]) result = {{(XLEN-8){1'b0}},         shifted[7:0]};
    else if (ld_type[LD_HU]) result = {{(XLEN-16){1'b0}},        shifted[15:0]};
  end

endmodule

// File: rtl/mem_stage_lsq.sv
// MEM stage with a circular queue of in-flight instructions. In-order SRAM
// responses are matched to the oldest waiting entry; responses owed to
// flushed requests are swallowed by discard_cnt.
module mem_stage_lsq
  import lsq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int RFA_W = 5
) (
  input  logic           clk,
  input  logic           reset,
  mem_stage_lsq_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = PW + 2;

  lsq_ctrl_t        ctrl_q  [DEPTH];
  lsq_ctrl_t        ctrl_d  [DEPTH];
  logic [XLEN-1:0]  pc_q    [DEPTH];
  logic [XLEN-1:0]  pc_d    [DEPTH];
  logic [XLEN-1:0]  alu_q   [DEPTH];
  logic [XLEN-1:0]  alu_d   [DEPTH];
  logic [XLEN-1:0]  data_q  [DEPTH];
  logic [XLEN-1:0]  data_d  [DEPTH];
  logic [RFA_W-1:0] waddr_q [DEPTH];
  logic [RFA_W-1:0] waddr_d [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DW-1:0]    discard_q, discard_d;

  logic             match_hit;
  logic [PW-1:0]    match_idx, scan_idx;
  logic [CW-1:0]    pend_cnt;
  lsq_ctrl_t        head_c;
  logic             resp_take, head_ready, wb_valid, retire, allowin, enq;
  logic [XLEN-1:0]  head_data, ld_result, wdata;
  logic [DEPTH-1:0]       blk_we_c;
  logic [DEPTH*RFA_W-1:0] blk_waddr_c;

  // Find the oldest entry still waiting for its response and count waiters.
  always_comb begin
    match_hit = 1'b0;
    match_idx = head_q;
    scan_idx  = head_q;
    pend_cnt  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PW'(i);
      if (!match_hit && ctrl_q[scan_idx].v && ctrl_q[scan_idx].req && !ctrl_q[scan_idx].got) begin
        match_hit = 1'b1;
        match_idx = scan_idx;
      end
      if (ctrl_q[i].v && ctrl_q[i].req && !ctrl_q[i].got) pend_cnt = pend_cnt + CW'(1);
    end
  end

  assign head_c     = ctrl_q[head_q];
  assign resp_take  = bus.data_ok & (discard_q == '0);
  assign head_ready = ~head_c.req | head_c.got | head_c.exc |
                      (resp_take & match_hit & (match_idx == head_q));
  assign head_data  = head_c.got ? data_q[head_q] : bus.rdata;
  assign wb_valid   = head_c.v & head_ready;
  assign retire     = wb_valid & bus.wb_allowin;
  assign allowin    = ~bus.flush & ((count_q < CW'(DEPTH)) | retire);
  assign enq        = bus.ex_valid & allowin;

  mem_ld_align #(.XLEN(XLEN)) u_ld_align (
    .data    (head_data),
    .addr    (alu_q[head_q][1:0]),
    .ld_type (head_c.ld_type),
    .result  (ld_result)
  );

  assign wdata = head_c.res_from_mem ? ld_result : alu_q[head_q];

  // Queue next state: flush wipes everything, else match, retire, enqueue.
  always_comb begin
    ctrl_d    = ctrl_q;
    pc_d      = pc_q;
    alu_d     = alu_q;
    data_d    = data_q;
    waddr_d   = waddr_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    discard_d = discard_q;
    if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) ctrl_d[i] = '0;
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      discard_d = discard_q + DW'(pend_cnt) + DW'(bus.ex_valid & bus.ex_req) - DW'(bus.data_ok);
    end else begin
      if (resp_take && match_hit) begin
        ctrl_d[match_idx].got = 1'b1;
        data_d[match_idx]     = bus.rdata;
      end
      if (bus.data_ok && (discard_q != '0)) discard_d = discard_q - DW'(1);
      if (retire) begin
        ctrl_d[head_q].v = 1'b0;
        head_d           = head_q + PW'(1);
      end
      // Enqueue after retire so a full queue can reuse the retiring slot.
      if (enq) begin
        ctrl_d[tail_q] = '{v: 1'b1, ld_type: bus.ex_ld_type,
                           res_from_mem: bus.ex_res_from_mem, csr_re: bus.ex_csr_re,
                           rf_we: bus.ex_rf_we, exc: bus.ex_exc, req: bus.ex_req,
                           got: 1'b0};
        pc_d[tail_q]    = bus.ex_pc;
        alu_d[tail_q]   = bus.ex_alu_result;
        waddr_d[tail_q] = bus.ex_rf_waddr;
        tail_d          = tail_q + PW'(1);
      end
      count_d = count_q + CW'(enq) - CW'(retire);
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_q[i]  <= '0;
        pc_q[i]    <= '0;
        alu_q[i]   <= '0;
        data_q[i]  <= '0;
        waddr_q[i] <= '0;
      end
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      discard_q <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      pc_q      <= pc_d;
      alu_q     <= alu_d;
      data_q    <= data_d;
      waddr_q   <= waddr_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      discard_q <= discard_d;
    end
  end

  // Per-entry write-back info for the ID-stage hazard check.
  always_comb begin
    blk_we_c    = '0;
    blk_waddr_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      blk_we_c[i]                   = ctrl_q[i].v & ctrl_q[i].rf_we;
      blk_waddr_c[i*RFA_W +: RFA_W] = waddr_q[i];
    end
  end

  assign bus.ex_allowin     = allowin;
  assign bus.mem_wb_valid   = wb_valid;
  assign bus.mem_pc         = pc_q[head_q];
  assign bus.mem_exc        = head_c.v & head_c.exc;
  assign bus.mem_alu_result = alu_q[head_q];
  assign bus.mem_rf_bus     = {head_c.res_from_mem, head_c.csr_re & head_c.v,
                               head_c.rf_we & head_c.v, waddr_q[head_q], wdata};
  assign bus.blk_we         = blk_we_c;
  assign bus.blk_waddr      = blk_waddr_c;
  assign bus.discard_cnt    = discard_q;

endmodule

// File: tb/tb_mem_stage_lsq.sv
// Directed bench for mem_stage_lsq (DEPTH=4, XLEN=32, RFA_W=5).
module tb_mem_stage_lsq;

  localparam logic [4:0] T_W  = 5'b10000;
  localparam logic [4:0] T_B  = 5'b01000;
  localparam logic [4:0] T_HU = 5'b00001;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  mem_stage_lsq_if #(.DEPTH(4), .XLEN(32), .RFA_W(5)) bus ();

  mem_stage_lsq #(.DEPTH(4), .XLEN(32), .RFA_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [31:0] pc, input logic req, input logic [4:0] ld,
                        input logic rfm, input logic [4:0] wa, input logic [31:0] alu,
                        input logic exc);
    bus.ex_valid        = 1'b1;
    bus.ex_pc           = pc;
    bus.ex_req          = req;
    bus.ex_ld_type      = ld;
    bus.ex_res_from_mem = rfm;
    bus.ex_csr_re       = 1'b0;
    bus.ex_rf_we        = 1'b1;
    bus.ex_rf_waddr     = wa;
    bus.ex_alu_result   = alu;
    bus.ex_exc          = exc;
  endtask

  task automatic clear_ex();
    bus.ex_valid        = 1'b0;
    bus.ex_pc           = '0;
    bus.ex_req          = 1'b0;
    bus.ex_ld_type      = '0;
    bus.ex_res_from_mem = 1'b0;
    bus.ex_csr_re       = 1'b0;
    bus.ex_rf_we        = 1'b0;
    bus.ex_rf_waddr     = '0;
    bus.ex_alu_result   = '0;
    bus.ex_exc          = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_ex();
    bus.flush = 1'b0; bus.data_ok = 1'b0; bus.rdata = '0; bus.wb_allowin = 1'b1;
    tick();
    tick();
    checks++; if (bus.mem_wb_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", bus.mem_wb_valid); end
    checks++; if (bus.ex_allowin !== 1'b1) begin failures++; $display("FAIL rst_allowin got=%0h exp=1", bus.ex_allowin); end
    checks++; if (bus.discard_cnt !== 4'd0) begin failures++; $display("FAIL rst_discard got=%0h exp=0", bus.discard_cnt); end
    checks++; if (bus.mem_rf_bus !== 40'd0) begin failures++; $display("FAIL rst_rfbus got=%0h exp=0", bus.mem_rf_bus); end
    reset = 1'b0;
  endtask

  task automatic test_ld_b();
    set_ex(32'h100, 1'b1, T_B, 1'b1, 5'd3, 32'h1001, 1'b0);
    checks++; if (bus.ex_allowin !== 1'b1) begin failures++; $display("FAIL ldb_allowin got=%0h exp=1", bus.ex_allowin); end
    tick();
    clear_ex();
    checks++; if (bus.mem_wb_valid !== 1'b0) begin failures++; $display("FAIL ldb_wait got=%0h exp=0", bus.mem_wb_valid); end
    tick();
    bus.data_ok = 1'b1; bus.rdata = 32'h0000_80FF;
    #1;
    checks++; if (bus.mem_wb_valid !== 1'b1) begin failures++; $display("FAIL ldb_valid got=%0h exp=1", bus.mem_wb_valid); end
    checks++; if (bus.mem_rf_bus[31:0] !== 32'hFFFF_FF80) begin failures++; $display("FAIL ldb_wdata got=%h exp=ffffff80", bus.mem_rf_bus[31:0]); end
    checks++; if (bus.mem_rf_bus[39:32] !== 8'b1010_0011) begin failures++; $display("FAIL ldb_ctrl got=%b exp=10100011", bus.mem_rf_bus[39:32]); end
    tick();
    bus.data_ok = 1'b0;
    #1;
    checks++; if (bus.mem_wb_valid !== 1'b0) begin failures++; $display("FAIL ldb_oneshot got=%0h exp=0", bus.mem_wb_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d;
    for (int k = 0; k < 4; k++) begin
      set_ex(32'h200 + 32'(4*k), 1'b1, T_W, 1'b1, 5'(k+1), 32'h2000 + 32'(4*k), 1'b0);
      checks++; if (bus.ex_allowin !== 1'b1) begin failures++; $display("FAIL b2b_allowin%0d got=%0h exp=1", k, bus.ex_allowin); end
      tick();
    end
    set_ex(32'h210, 1'b1, T_W, 1'b1, 5'd5, 32'h2010, 1'b0);
    #1;
    checks++; if (bus.ex_allowin !== 1'b0) begin failures++; $display("FAIL full_allowin got=%0h exp=0", bus.ex_allowin); end
    checks++; if (bus.blk_we !== 4'hF) begin failures++; $display("FAIL full_blk_we got=%h exp=f", bus.blk_we); end
    checks++; if (bus.mem_wb_valid !== 1'b0) begin failures++; $display("FAIL full_novalid got=%0h exp=0", bus.mem_wb_valid); end
    bus.data_ok = 1'b1; bus.rdata = 32'h11;
    #1;
    checks++; if (bus.ex_allowin !== 1'b1) begin failures++; $display("FAIL full_retire_allowin got=%0h exp=1", bus.ex_allowin); end
    for (int k = 0; k < 4; k++) begin
      exp_d = 32'h11 * 32'(k+1);
      bus.rdata = exp_d;
      #1;
      checks++; if (bus.mem_wb_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid%0d got=%0h exp=1", k, bus.mem_wb_valid); end
      checks++; if (bus.mem_rf_bus[31:0] !== exp_d) begin failures++; $display("FAIL b2b_wdata%0d got=%h exp=%h", k, bus.mem_rf_bus[31:0], exp_d); end
      checks++; if (bus.mem_pc !== 32'h200 + 32'(4*k)) begin failures++; $display("FAIL b2b_pc%0d got=%h exp=%h", k, bus.mem_pc, 32'h200 + 32'(4*k)); end
      tick();
      clear_ex();
    end
    bus.rdata = 32'h55;
    #1;
    checks++; if (bus.mem_wb_valid !== 1'b1) begin failures++; $display("FAIL b2b_new_valid got=%0h exp=1", bus.mem_wb_valid); end
    checks++; if (bus.mem_rf_bus[31:0] !== 32'h55) begin failures++; $display("FAIL b2b_new_wdata got=%h exp=55", bus.mem_rf_bus[31:0]); end
    checks++; if (bus.mem_pc !== 32'h210) begin failures++; $display("FAIL b2b_new_pc got=%h exp=210", bus.mem_pc); end
    tick();
    bus.data_ok = 1'b0;
    #1;
    checks++; if (bus.mem_wb_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%0h exp=0", bus.mem_wb_valid); end
  endtask

  task automatic test_bypass();
    set_ex(32'h300, 1'b1, T_HU, 1'b1, 5'd7, 32'h3002, 1'b0);
    tick();
    clear_ex();
    bus.data_ok = 1'b1; bus.rdata = 32'hABCD_1234;
    #1;
    checks++; if (bus.mem_wb_valid !== 1'b1) begin failures++; $display("FAIL byp_valid got=%0h exp=1", bus.mem_wb_valid); end
    checks++; if (bus.mem_rf_bus[31:0] !== 32'h0000_ABCD) begin failures++; $display("FAIL byp_wdata got=%h exp=0000abcd", bus.mem_rf_bus[31:0]); end
    tick();
    bus.data_ok = 1'b0;
    #1;
    checks++; if (bus.mem_wb_valid !== 1'b0) begin failures++; $display("FAIL byp_gone got=%0h exp=0", bus.mem_wb_valid); end
  endtask

  task automatic test_flush();
    set_ex(32'h400, 1'b1, T_W, 1'b1, 5'd1, 32'h4000, 1'b0);
    tick();
    set_ex(32'h404, 1'b1, T_W, 1'b1, 5'd2, 32'h4004, 1'b0);
    tick();
    set_ex(32'h408, 1'b1, T_W, 1'b1, 5'd3, 32'h4008, 1'b0);
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.ex_allowin !== 1'b0) begin failures++; $display("FAIL fl_allowin got=%0h exp=0", bus.ex_allowin); end
    tick();
    bus.flush = 1'b0;
    clear_ex();
    #1;
    checks++; if (bus.discard_cnt !== 4'd3) begin failures++; $display("FAIL fl_discard got=%0d exp=3", bus.discard_cnt); end
    checks++; if (bus.blk_we !== 4'h0) begin failures++; $display("FAIL fl_blk_we got=%h exp=0", bus.blk_we); end
    set_ex(32'h40C, 1'b1, T_W, 1'b1, 5'd4, 32'h400C, 1'b0);
    #1;
    checks++; if (bus.ex_allowin !== 1'b1) begin failures++; $display("FAIL fl_enq_allowin got=%0h exp=1", bus.ex_allowin); end
    tick();
    clear_ex();
    for (int k = 0; k < 3; k++) begin
      bus.data_ok = 1'b1; bus.rdata = 32'hDEAD_0000 + 32'(k);
      #1;
      checks++; if (bus.mem_wb_valid !== 1'b0) begin failures++; $display("FAIL fl_noretire%0d got=%0h exp=0", k, bus.mem_wb_valid); end
      tick();
      checks++; if (bus.discard_cnt !== 4'(2-k)) begin failures++; $display("FAIL fl_dec%0d got=%0d exp=%0d", k, bus.discard_cnt, 2-k); end
    end
    bus.rdata = 32'h5555_AAAA;
    #1;
    checks++; if (bus.mem_wb_valid !== 1'b1) begin failures++; $display("FAIL fl_new_valid got=%0h exp=1", bus.mem_wb_valid); end
    checks++; if (bus.mem_rf_bus[31:0] !== 32'h5555_AAAA) begin failures++; $display("FAIL fl_new_wdata got=%h exp=5555aaaa", bus.mem_rf_bus[31:0]); end
    checks++; if (bus.mem_pc !== 32'h40C) begin failures++; $display("FAIL fl_new_pc got=%h exp=40c", bus.mem_pc); end
    tick();
    bus.data_ok = 1'b0;
  endtask

  task automatic test_exc_stall();
    bus.wb_allowin = 1'b0;
    set_ex(32'h500, 1'b0, 5'b0, 1'b0, 5'd9, 32'h1234, 1'b1);
    tick();
    clear_ex();
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.mem_wb_valid !== 1'b1) begin failures++; $display("FAIL exc_hold%0d got=%0h exp=1", k, bus.mem_wb_valid); end
      checks++; if (bus.mem_exc !== 1'b1) begin failures++; $display("FAIL exc_flag%0d got=%0h exp=1", k, bus.mem_exc); end
      tick();
    end
    bus.wb_allowin = 1'b1;
    #1;
    checks++; if (bus.mem_pc !== 32'h500) begin failures++; $display("FAIL exc_pc got=%h exp=500", bus.mem_pc); end
    checks++; if (bus.mem_rf_bus[31:0] !== 32'h1234) begin failures++; $display("FAIL exc_wdata got=%h exp=1234", bus.mem_rf_bus[31:0]); end
    checks++; if (bus.mem_alu_result !== 32'h1234) begin failures++; $display("FAIL exc_alu got=%h exp=1234", bus.mem_alu_result); end
    tick();
    checks++; if (bus.mem_wb_valid !== 1'b0) begin failures++; $display("FAIL exc_retired got=%0h exp=0", bus.mem_wb_valid); end
    checks++; if (bus.mem_exc !== 1'b0) begin failures++; $display("FAIL exc_cleared got=%0h exp=0", bus.mem_exc); end
  endtask

  task automatic test_reset_mid();
    set_ex(32'h600, 1'b1, T_W, 1'b1, 5'd1, 32'h6000, 1'b0);
    tick();
    set_ex(32'h604, 1'b1, T_W, 1'b1, 5'd2, 32'h6004, 1'b0);
    tick();
    clear_ex();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.wb_allowin = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_ex(32'h610 + 32'(4*k), 1'b0, 5'b0, 1'b0, 5'(10+k), 32'(k), 1'b0);
      tick();
    end
    clear_ex();
    checks++; if (bus.discard_cnt !== 4'd2) begin failures++; $display("FAIL rm_discard got=%0d exp=2", bus.discard_cnt); end
    checks++; if (bus.blk_we !== 4'b0111) begin failures++; $display("FAIL rm_blk_we got=%b exp=0111", bus.blk_we); end
    checks++; if (bus.mem_wb_valid !== 1'b1) begin failures++; $display("FAIL rm_valid got=%0h exp=1", bus.mem_wb_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus.mem_wb_valid !== 1'b0) begin failures++; $display("FAIL rm_r_valid got=%0h exp=0", bus.mem_wb_valid); end
    checks++; if (bus.ex_allowin !== 1'b1) begin failures++; $display("FAIL rm_r_allowin got=%0h exp=1", bus.ex_allowin); end
    checks++; if (bus.discard_cnt !== 4'd0) begin failures++; $display("FAIL rm_r_discard got=%0d exp=0", bus.discard_cnt); end
    checks++; if (bus.blk_we !== 4'h0) begin failures++; $display("FAIL rm_r_blk_we got=%h exp=0", bus.blk_we); end
    checks++; if (bus.blk_waddr !== 20'h0) begin failures++; $display("FAIL rm_r_blk_waddr got=%h exp=0", bus.blk_waddr); end
    checks++; if (bus.mem_pc !== 32'h0) begin failures++; $display("FAIL rm_r_pc got=%h exp=0", bus.mem_pc); end
    checks++; if (bus.mem_rf_bus !== 40'h0) begin failures++; $display("FAIL rm_r_rfbus got=%h exp=0", bus.mem_rf_bus); end
    checks++; if (bus.mem_exc !== 1'b0) begin failures++; $display("FAIL rm_r_exc got=%0h exp=0", bus.mem_exc); end
    checks++; if (bus.mem_alu_result !== 32'h0) begin failures++; $display("FAIL rm_r_alu got=%h exp=0", bus.mem_alu_result); end
    bus.wb_allowin = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ld_b();
    test_back_to_back();
    test_bypass();
    test_flush();
    test_exc_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsq.md
# mem_stage_lsq

Parametrised successor MEM pipeline stage holding up to DEPTH in-flight instructions between EX and WB, so several data-SRAM loads/stores can be outstanding at once. Responses (`data_ok`) return in order and are matched to the oldest waiting entry. Flushes from WB kill all entries; responses for requests already issued are silently discarded. Loaded data is aligned and sign/zero-extended here before the result goes to WB.

## Interface
- DEPTH, 4: queue entries (max outstanding instructions); power of two, ≥2
- XLEN, 32: data/address width
- RFA_W, 5: register-file address width
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- ex_valid  in  1  EX offers an instruction
- ex_allowin  out  1  MEM accepts this cycle (`ex_valid & ex_allowin` = enqueue)
- ex_pc  in  XLEN  PC
- ex_req  in  1  this instruction issued a data-SRAM request (accepted by SRAM)
- ex_ld_type  in  5  {ld_w, ld_b, ld_h, ld_bu, ld_hu}
- ex_res_from_mem, ex_csr_re, ex_rf_we  in  1 each
- ex_rf_waddr  in  RFA_W
- ex_alu_result  in  XLEN  result / effective address
- ex_exc  in  1  instruction carries an exception (`ex_req` is then 0)
- flush  in  1  WB exception/ertn: kill everything
- data_ok  in  1  SRAM response strobe
- rdata  in  XLEN  SRAM read data
- wb_allowin  in  1
- mem_wb_valid  out  1  head retires when `wb_allowin`
- mem_pc  out  XLEN
- mem_rf_bus  out  XLEN+RFA_W+3  {res_from_mem, csr_re&v, rf_we&v, rf_waddr, rf_wdata}
- mem_exc  out  1  head valid with exception
- mem_alu_result  out  XLEN
- blk_we  out  DEPTH  per-entry valid&rf_we (ID hazard)
- blk_waddr  out  DEPTH*RFA_W  per-entry rf_waddr
- discard_cnt  out  $clog2(DEPTH)+2  responses pending discard

## Operation
- Circular queue: head/tail pointers (log2 DEPTH bits, wrap), count 0..DEPTH.
- Entry fields: pc, ld_type, res_from_mem, csr_re, rf_we, waddr, alu_result, exc, req, got, data.
- Enqueue: fields written at tail, `got`=0, tail++.
- Response match, when `data_ok` and `discard_cnt`==0: the oldest entry with `req & ~got` sets `got`=1 and latches `rdata`. When `discard_cnt`>0, `data_ok` decrements `discard_cnt` and no entry changes.
- Head ready_go = `~req | got | exc | (data_ok & discard_cnt==0 & head is oldest waiting)`. The last term is a bypass: `rdata` goes to the aligner in the same cycle.
- `mem_wb_valid` = head valid & ready_go. Retire = `mem_wb_valid & wb_allowin`, which advances head.
- `ex_allowin` = `~flush & (count<DEPTH | retire)`.
- Alignment: shift = alu_result[1:0]*8, then extract. ld_b/ld_h sign-extend; ld_bu/ld_hu zero-extend; ld_w passes through. wdata = res_from_mem ? aligned : alu_result.
- Flush, taking priority over enqueue and retire:
  - All entries invalid; head=tail=0; count=0.
  - discard_cnt += (#entries req&~got) + (ex_valid&ex_req) − data_ok. The data_ok in that cycle is consumed either by discard or by the killed entry.
- While discard_cnt>0, new entries may enqueue. Their responses arrive after the discarded ones (in-order SRAM).

## Timing
- Reset: all outputs 0; count, pointers and discard_cnt 0; `ex_allowin`=1.
- Enqueue-to-head latency is 1 cycle. An empty queue plus a non-mem instruction gives `mem_wb_valid` the cycle after acceptance.
- Load at head with data_ok in that cycle retires in the same cycle (zero-cycle bypass).
- Full queue with head retiring accepts a new entry in the same cycle (count unchanged).
- Simultaneous enqueue and response: the new entry is never matched by that cycle's data_ok.
- Flush same cycle as enqueue: the instruction is dropped, and its request is counted if `ex_req`.
- Reset mid-operation clears discard_cnt. The SRAM is reset alongside.

## Structure
- Shared package `lsq_pkg`: ld_type bit positions, rf_bus field offsets and width, entry struct.
- Sub-module `mem_ld_align` (combinational): inputs data, addr[1:0], ld_type; output extended result. The queue, matcher and discard counter stay in the top module.

## Test plan
- Single ld_b at addr …1, rdata 0x0000_80FF, data_ok 2 cycles later → wdata 0xFFFF_FF80, mem_wb_valid 1 cycle only.
- Four back-to-back ld_w (DEPTH=4), no data_ok → ex_allowin=0 on the 5th. Data_ok ×4 with 0x11,0x22,0x33,0x44 → retired in order with matching values.
- ld_hu at head, data_ok same cycle as head valid with rdata 0xABCD_1234, addr 2 → retires that cycle with wdata 0x0000_ABCD.
- Two loads outstanding, flush while ex_valid&ex_req → discard_cnt=3. The next 3 data_ok cause no retire; a 4th load's response retires correctly.
- ALU op, ex_exc=1 entry, wb_allowin held 0 for 3 cycles → mem_wb_valid stays 1 with mem_exc=1, retires when wb_allowin rises.
- Reset asserted with 3 entries and discard_cnt=2 → next cycle all outputs 0, ex_allowin=1.
